lfsr_gen: RTL and testbench

Parametrised Fibonacci LFSR sequencer with seed load, programmable shift count and completion flag. It is the generalised successor of the team's fixed 7-bit, 8-shift LFSR. Width, feedback taps and counter width are parameters. A load/run/done state machine with a per-shift strobe lets downstream pattern logic consume each value as it is produced.

---
 rtl/lfsr_gen_if.sv | 25 ++
 rtl/lfsr_gen.sv | 79 +++++++
 tb/tb_lfsr_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lfsr_gen_if.sv
// Handshake bundle for lfsr_gen: seed/load/count/enable requests in, LFSR value and status out.
// master drives the requests, slave is the sequencer.
interface lfsr_gen_if #(
    parameter int unsigned WIDTH   = 7,
    parameter int unsigned COUNT_W = 4
);
    logic [WIDTH-1:0]   seed;
    logic               load;
    logic [COUNT_W-1:0] n_shifts;
    logic               enable;
    logic [WIDTH-1:0]   lfsr_out;
    logic               shift_valid;
    logic               busy;
    logic               done;

    modport master (
        output seed, load, n_shifts, enable,
        input  lfsr_out, shift_valid, busy, done
    );

    modport slave (
        input  seed, load, n_shifts, enable,
        output lfsr_out, shift_valid, busy, done
    );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR sequencer: loads a seed, performs a programmed number of
// enabled shifts with a per-shift strobe, then parks in a sticky DONE state.
module lfsr_gen #(
    parameter int unsigned          WIDTH        = 7,
    parameter logic [WIDTH-1:0]     TAPS         = 7'b1100000,
    parameter int unsigned          COUNT_W      = 4,
    parameter logic [WIDTH-1:0]     DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic        clk,
    input  logic        rst,
    lfsr_gen_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] target_q, target_d;
    logic               valid_q, valid_d;

    logic [WIDTH-1:0]   lfsr_shift;
    logic [COUNT_W-1:0] count_inc;

    assign lfsr_shift = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    assign count_inc  = count_q + COUNT_W'(1);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        count_d  = count_q;
        target_d = target_q;
        valid_d  = 1'b0;

        if (bus.load) begin
            // A zero seed would lock the register, so substitute the default.
            lfsr_d   = (bus.seed == '0) ? DEFAULT_SEED : bus.seed;
            count_d  = '0;
            target_d = bus.n_shifts;
            state_d  = (bus.n_shifts == '0) ? StDone : StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (bus.enable) begin
                        lfsr_d  = lfsr_shift;
                        count_d = count_inc;
                        valid_d = 1'b1;
                        if (count_inc == target_q) begin
                            state_d = StDone;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            lfsr_q   <= '0;
            count_q  <= '0;
            target_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            count_q  <= count_d;
            target_q <= target_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.lfsr_out    = lfsr_q;
    assign bus.shift_valid = valid_q;
    assign bus.busy        = (state_q == StRun);
    assign bus.done        = (state_q == StDone);

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: a shift-counting behavioural model checked every cycle, literal pins on
// the model, and a full-period run on a second instance with a wider counter.
module tb_lfsr_gen;

    localparam logic [6:0] TAPS = 7'b1100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lfsr_gen_if #(.WIDTH(7), .COUNT_W(4)) bus_a ();
    lfsr_gen_if #(.WIDTH(7), .COUNT_W(7)) bus_b ();

    lfsr_gen #(.WIDTH(7), .TAPS(TAPS), .COUNT_W(4), .DEFAULT_SEED(7'h01)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    lfsr_gen #(.WIDTH(7), .TAPS(TAPS), .COUNT_W(7), .DEFAULT_SEED(7'h01)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    // Model: mode 0 idle, 1 running, 2 finished; m_left counts shifts still owed.
    int         m_mode = 0;
    logic [6:0] m_val  = '0;
    int         m_left = 0;
    bit         m_sv   = 1'b0;

    function automatic logic [6:0] next_val(input logic [6:0] v);
        int ones = 0;
        for (int i = 0; i < 7; i++) begin
            if (TAPS[i] && v[i]) ones++;
        end
        return 7'((int'(v) * 2) % 128 + ones % 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle with the given inputs held on dut_a; model follows the same edge.
    task automatic apply(input bit ld, input logic [6:0] sd, input int n, input bit en);
        bus_a.load     = ld;
        bus_a.seed     = sd;
        bus_a.n_shifts = 4'(n);
        bus_a.enable   = en;
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_val = '0; m_left = 0; m_sv = 1'b0;
        end else if (ld) begin
            m_val  = (sd == 0) ? 7'h01 : sd;
            m_left = n;
            m_mode = (n == 0) ? 2 : 1;
            m_sv   = 1'b0;
        end else if (m_mode == 1 && en) begin
            m_val = next_val(m_val);
            m_left--;
            m_sv  = 1'b1;
            if (m_left == 0) m_mode = 2;
        end else begin
            m_sv = 1'b0;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("lfsr_out", 32'(bus_a.lfsr_out), 32'(m_val));
            check("shift_valid", 32'(bus_a.shift_valid), 32'(m_sv));
            check("busy", 32'(bus_a.busy), 32'(m_mode == 1));
            check("done", 32'(bus_a.done), 32'(m_mode == 2));
        end
    end

    logic [6:0] basic_seq [8] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03, 7'h06};
    bit         gap_pat   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int sv_cnt;
        int cyc;
        bit seen_one;
        bit seen_zero;

        bus_b.load = 1'b0; bus_b.seed = '0; bus_b.n_shifts = '0; bus_b.enable = 1'b0;
        apply(0, 0, 0, 0);
        checking = 1'b1;
        apply(0, 0, 0, 1);
        rst = 1'b0;
        apply(0, 0, 0, 1);

        // Basic run
        apply(1, 7'h01, 8, 0);
        check("pin_basic_load", 32'(m_val), 32'h01);
        sv_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            apply(0, 0, 0, 1);
            check($sformatf("pin_basic_%0d", i), 32'(m_val), 32'(basic_seq[i]));
            if (bus_a.shift_valid) sv_cnt++;
        end
        check("basic_sv_count", 32'(sv_cnt), 32'd8);
        check("pin_basic_done", 32'(m_mode), 32'd2);
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 1);

        // Zero seed, then zero count
        apply(1, 7'h00, 3, 0);
        check("pin_zero_seed", 32'(m_val), 32'h01);
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 1);
        check("pin_zero_seed_end", 32'(m_val), 32'h08);
        check("pin_zero_seed_done", 32'(m_mode), 32'd2);
        apply(1, 7'h33, 0, 1);
        check("pin_zero_cnt", 32'(m_val), 32'h33);
        apply(0, 0, 0, 1);

        // Enable gaps
        apply(1, 7'h01, 4, 0);
        for (int i = 0; i < 7; i++) apply(0, 0, 0, gap_pat[i]);
        check("pin_gap_end", 32'(m_val), 32'h10);
        check("pin_gap_done", 32'(m_mode), 32'd2);

        // Restart mid-run; load wins over enable
        apply(1, 7'h01, 8, 0);
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 1);
        apply(1, 7'h55, 2, 1);
        check("pin_restart", 32'(m_val), 32'h55);
        apply(0, 0, 0, 1);
        check("pin_restart_1", 32'(m_val), 32'h2B);
        apply(0, 0, 0, 1);
        check("pin_restart_2", 32'(m_val), 32'h57);
        apply(0, 0, 0, 1);

        // Reset mid-run beats a simultaneous load
        apply(1, 7'h01, 8, 0);
        apply(0, 0, 0, 1);
        apply(0, 0, 0, 1);
        rst = 1'b1;
        apply(1, 7'h12, 5, 1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 1);

        // Full period on the wide-counter instance
        bus_b.load = 1'b1; bus_b.seed = 7'h01; bus_b.n_shifts = 7'd127; bus_b.enable = 1'b0;
        apply(0, 0, 0, 0);
        bus_b.load = 1'b0; bus_b.enable = 1'b1;
        check("period_load", 32'(bus_b.lfsr_out), 32'h01);
        sv_cnt = 0; cyc = 0; seen_one = 1'b0; seen_zero = 1'b0;
        while (!bus_b.done && cyc < 200) begin
            apply(0, 0, 0, 0);
            cyc++;
            if (bus_b.shift_valid) sv_cnt++;
            if (bus_b.lfsr_out == 7'h00) seen_zero = 1'b1;
            if (!bus_b.done && bus_b.lfsr_out == 7'h01) seen_one = 1'b1;
        end
        check("period_done", 32'(bus_b.done), 32'd1);
        check("period_final", 32'(bus_b.lfsr_out), 32'h01);
        check("period_shifts", 32'(sv_cnt), 32'd127);
        check("period_no_early_01", 32'(seen_one), 32'd0);
        check("period_never_zero", 32'(seen_zero), 32'd0);
        bus_b.enable = 1'b0;
        apply(0, 0, 0, 0);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
